lsu_ctrl: RTL and testbench

- Load/store unit in the MEM stage. It is the initiator side of the data-memory port: it drives the read codes, write codes, address and store data that the data memory responds to.
- Converts RISC-V byte/half/word loads and stores at any byte address into word-granular memory accesses.
- Performs read-modify-write for sub-word and unaligned stores, and splits accesses that cross a word boundary into two word accesses.
- Stalls the pipeline via req_ready until the access completes.

---
 rtl/lsu_pkg.sv | 49 ++++
 rtl/lsu_lane.sv | 70 +++++++
 rtl/lsu_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RISC-V load/store funct3 encodings
//   - data-memory read/write codes driven on the memory port
//   - access sizes in bytes and the LSU state enum
//   - helpers decoding funct3 into access size and signedness
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] MEM_RD_OFF = 3'b000;
    localparam logic [2:0] MEM_RD_LW  = 3'b001;
    localparam logic [1:0] MEM_WR_OFF = 2'b00;
    localparam logic [1:0] MEM_WR_SW  = 2'b01;

    localparam logic [2:0] SZ_B = 3'd1;
    localparam logic [2:0] SZ_H = 3'd2;
    localparam logic [2:0] SZ_W = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_WR0  = 3'd3,
        ST_WR1  = 3'd4
    } lsu_state_t;

    // Access size in bytes; unused encodings behave as a full word.
    function automatic logic [2:0] f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: f3_size = SZ_B;
            F3_H, F3_HU: f3_size = SZ_H;
            F3_W:        f3_size = SZ_W;
            default:     f3_size = SZ_W;
        endcase
    endfunction

    // Only LB and LH sign-extend.
    function automatic logic f3_signed(input logic [2:0] f3);
        case (f3)
            F3_B, F3_H: f3_signed = 1'b1;
            default:    f3_signed = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: combinational byte-lane steering for the LSU.
//   off      in  byte offset inside word0
//   size     in  access size in bytes (1, 2 or 4)
//   sgn      in  sign-extend the load result
//   word0    in  memory word at the aligned address
//   word1    in  memory word at the aligned address + 4
//   wdata    in  store data (low bytes used)
//   load_val out extracted and extended load value
//   store_w0 out word0 with the store bytes merged in
//   store_w1 out word1 with the store bytes merged in
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    input  logic        sgn,
    input  logic [31:0] word0,
    input  logic [31:0] word1,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] store_w0,
    output logic [31:0] store_w1
);

    logic [5:0]  sh_s;
    logic [63:0] pair_s;
    logic [31:0] shifted_s;
    logic [31:0] lane_mask_s;
    logic [63:0] mask_s;
    logic [63:0] ins_s;
    logic [63:0] merged_s;

    // Extract the load value and merge store bytes across the two-word window.
    always_comb begin
        sh_s      = {1'b0, off, 3'b000};
        pair_s    = {word1, word0};
        shifted_s = 32'(pair_s >> sh_s);

        case (size)
            SZ_B:    lane_mask_s = 32'h0000_00FF;
            SZ_H:    lane_mask_s = 32'h0000_FFFF;
            default: lane_mask_s = 32'hFFFF_FFFF;
        endcase

        case (size)
            SZ_B: begin
                if (sgn) begin
                    load_val = {{24{shifted_s[7]}}, shifted_s[7:0]};
                end else begin
                    load_val = {24'h00_0000, shifted_s[7:0]};
                end
            end
            SZ_H: begin
                if (sgn) begin
                    load_val = {{16{shifted_s[15]}}, shifted_s[15:0]};
                end else begin
                    load_val = {16'h0000, shifted_s[15:0]};
                end
            end
            default: load_val = shifted_s;
        endcase

        mask_s   = {32'h0000_0000, lane_mask_s} << sh_s;
        ins_s    = {32'h0000_0000, wdata & lane_mask_s} << sh_s;
        merged_s = (pair_s & ~mask_s) | ins_s;
        store_w0 = merged_s[31:0];
        store_w1 = merged_s[63:32];
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: MEM-stage load/store unit driving a word-granular data memory.
// Byte/half/word loads and stores at any address become one or two word
// reads, optionally followed by one or two word writes (read-modify-write).
// Optional build macro LSU_MISALIGN_TRAP_EN: word-crossing accesses are not
// split but answered at once with resp_err = 1 and no memory cycle.
// Ports:
//   clk, rst (sync, active-high)
//   req_valid/req_ready, req_store, req_funct3, req_addr, req_wdata : request
//   resp_valid, resp_data, resp_err : one-cycle completion
//   mem_read, mem_write, r, rs2     : memory codes, word address, write word
//   read_data_out                   : combinational memory read data
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic [2:0]        mem_read,
    output logic [1:0]        mem_write,
    output logic [ADDR_W-1:0] r,
    output logic [DATA_W-1:0] rs2,
    input  logic [DATA_W-1:0] read_data_out
);

    lsu_state_t        state_r, state_nx_s;
    logic [ADDR_W-1:0] addr_r;
    logic [2:0]        funct3_r;
    logic              store_r;
    logic [31:0]       wdata_r, word0_r, word1_r;

    logic              idle_s, accept_s, done_s, err_s;
    logic [ADDR_W-1:0] cur_addr_s, w0_addr_s, w1_addr_s;
    logic [2:0]        cur_f3_s, size_s;
    logic              cur_store_s, sgn_s, cross_s, aligned_sw_s;
    logic [31:0]       cur_wdata_s, word0_s, word1_s;
    logic [31:0]       load_val_s, store_w0_s, store_w1_s;
    logic [2:0]        mem_read_nx_s;
    logic [1:0]        mem_write_nx_s;
    logic [ADDR_W-1:0] r_nx_s;
    logic [31:0]       rs2_nx_s, resp_data_nx_s;

    assign req_ready = (state_r == ST_IDLE);

    // Decode the access in flight: live request while idle, latched copy otherwise.
    always_comb begin
        idle_s   = (state_r == ST_IDLE);
        accept_s = idle_s && req_valid;
        if (idle_s) begin
            cur_addr_s  = req_addr;
            cur_f3_s    = req_funct3;
            cur_store_s = req_store;
            cur_wdata_s = req_wdata;
        end else begin
            cur_addr_s  = addr_r;
            cur_f3_s    = funct3_r;
            cur_store_s = store_r;
            cur_wdata_s = wdata_r;
        end
        size_s       = f3_size(cur_f3_s);
        sgn_s        = f3_signed(cur_f3_s);
        cross_s      = ({2'b00, cur_addr_s[1:0]} + {1'b0, size_s}) > 4'd4;
        aligned_sw_s = cur_store_s && (size_s == SZ_W) && (cur_addr_s[1:0] == 2'b00);
        w0_addr_s    = {cur_addr_s[ADDR_W-1:2], 2'b00};
        w1_addr_s    = w0_addr_s + {{(ADDR_W-3){1'b0}}, 3'b100};
        // Read data is combinational, so the word being read this cycle is used directly.
        if (state_r == ST_RD0) begin
            word0_s = read_data_out;
        end else begin
            word0_s = word0_r;
        end
        if (state_r == ST_RD1) begin
            word1_s = read_data_out;
        end else begin
            word1_s = word1_r;
        end
    end

    lsu_lane u_lane (
        .off      (cur_addr_s[1:0]),
        .size     (size_s),
        .sgn      (sgn_s),
        .word0    (word0_s),
        .word1    (word1_s),
        .wdata    (cur_wdata_s),
        .load_val (load_val_s),
        .store_w0 (store_w0_s),
        .store_w1 (store_w1_s)
    );

    // Next-state logic; done_s marks the edge that completes an access.
    always_comb begin
        state_nx_s = state_r;
        done_s     = 1'b0;
        err_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    if (cross_s) begin
                        state_nx_s = ST_IDLE;
                        done_s     = 1'b1;
                        err_s      = 1'b1;
                    end else if (aligned_sw_s) begin
                        state_nx_s = ST_WR0;
                    end else begin
                        state_nx_s = ST_RD0;
                    end
`else
                    if (aligned_sw_s) begin
                        state_nx_s = ST_WR0;
                    end else begin
                        state_nx_s = ST_RD0;
                    end
`endif
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RD0: begin
                if (cross_s) begin
                    state_nx_s = ST_RD1;
                end else if (cur_store_s) begin
                    state_nx_s = ST_WR0;
                end else begin
                    state_nx_s = ST_IDLE;
                    done_s     = 1'b1;
                end
            end
            ST_RD1: begin
                if (cur_store_s) begin
                    state_nx_s = ST_WR0;
                end else begin
                    state_nx_s = ST_IDLE;
                    done_s     = 1'b1;
                end
            end
            ST_WR0: begin
                if (cross_s) begin
                    state_nx_s = ST_WR1;
                end else begin
                    state_nx_s = ST_IDLE;
                    done_s     = 1'b1;
                end
            end
            ST_WR1: begin
                state_nx_s = ST_IDLE;
                done_s     = 1'b1;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Memory-port and response values for the coming cycle, so all outputs are flops.
    always_comb begin
        mem_read_nx_s  = MEM_RD_OFF;
        mem_write_nx_s = MEM_WR_OFF;
        r_nx_s         = r;
        rs2_nx_s       = rs2;
        case (state_nx_s)
            ST_RD0: begin
                mem_read_nx_s = MEM_RD_LW;
                r_nx_s        = w0_addr_s;
            end
            ST_RD1: begin
                mem_read_nx_s = MEM_RD_LW;
                r_nx_s        = w1_addr_s;
            end
            ST_WR0: begin
                mem_write_nx_s = MEM_WR_SW;
                r_nx_s         = w0_addr_s;
                rs2_nx_s       = store_w0_s;
            end
            ST_WR1: begin
                mem_write_nx_s = MEM_WR_SW;
                r_nx_s         = w1_addr_s;
                rs2_nx_s       = store_w1_s;
            end
            default: begin
                mem_read_nx_s  = MEM_RD_OFF;
                mem_write_nx_s = MEM_WR_OFF;
            end
        endcase
        if (done_s && !cur_store_s && !err_s) begin
            resp_data_nx_s = load_val_s;
        end else begin
            resp_data_nx_s = 32'h0000_0000;
        end
    end

    // State, request latches, read-word capture and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            addr_r     <= '0;
            funct3_r   <= 3'b000;
            store_r    <= 1'b0;
            wdata_r    <= 32'h0000_0000;
            word0_r    <= 32'h0000_0000;
            word1_r    <= 32'h0000_0000;
            mem_read   <= MEM_RD_OFF;
            mem_write  <= MEM_WR_OFF;
            r          <= '0;
            rs2        <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            if (accept_s) begin
                addr_r   <= req_addr;
                funct3_r <= req_funct3;
                store_r  <= req_store;
                wdata_r  <= req_wdata;
            end
            if (state_r == ST_RD0) begin
                word0_r <= read_data_out;
            end
            if (state_r == ST_RD1) begin
                word1_r <= read_data_out;
            end
            mem_read   <= mem_read_nx_s;
            mem_write  <= mem_write_nx_s;
            r          <= r_nx_s;
            rs2        <= rs2_nx_s;
            resp_valid <= done_s;
            resp_data  <= resp_data_nx_s;
            resp_err   <= err_s;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed bench for lsu_ctrl with a small word memory model
// (combinational read, write on negedge while mem_write = 01).
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_data, r, rs2, read_data_out;
    logic [2:0]  mem_read;
    logic [1:0]  mem_write;

    logic [31:0] mem [0:15];
    logic        mem_load;

    int          n_chk = 0;
    int          n_bad = 0;

    int          nbusy;
    logic        got_resp, rerr, busy_ready;
    logic [31:0] rdata;
    logic [2:0]  tr_rd  [0:7];
    logic [1:0]  tr_wr  [0:7];
    logic [31:0] tr_r   [0:7];
    logic [31:0] tr_rs2 [0:7];

    lsu_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_store     (req_store),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .resp_err      (resp_err),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .r             (r),
        .rs2           (rs2),
        .read_data_out (read_data_out)
    );

    always #5 clk = ~clk;

    assign read_data_out = mem[r[5:2]];

    // Memory model: preload image on request, otherwise write on negedge.
    always @(negedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h1122_3344;
            mem[1] <= 32'h8899_AABB;
        end else if (mem_write == 2'b01) begin
            mem[r[5:2]] <= rs2;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic mem_reset();
        @(posedge clk);
        mem_load = 1'b1;
        @(posedge clk);
        #1 mem_load = 1'b0;
    endtask

    // Issue one request and trace each busy cycle until resp_valid (bounded).
    task automatic run_req(input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_funct3 = f3;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        nbusy = 0; got_resp = 1'b0; busy_ready = 1'b0;
        rdata = 32'h0; rerr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!got_resp) begin
                if (resp_valid) begin
                    got_resp = 1'b1;
                    rdata    = resp_data;
                    rerr     = resp_err;
                end else begin
                    tr_rd[nbusy]  = mem_read;
                    tr_wr[nbusy]  = mem_write;
                    tr_r[nbusy]   = r;
                    tr_rs2[nbusy] = rs2;
                    busy_ready    = busy_ready | req_ready;
                    nbusy++;
                end
            end
            if (got_resp) break;
        end
        chk("resp_seen", {63'd0, got_resp}, 64'd1);
    endtask

    initial begin
        logic saw_wr, saw_resp;
        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; mem_load = 1'b1;
        repeat (3) @(posedge clk);
        #1 mem_load = 1'b0;
        @(negedge clk);
        chk("rst_ready",  {63'd0, req_ready},  64'd1);
        chk("rst_rvalid", {63'd0, resp_valid}, 64'd0);
        chk("rst_codes",  {59'd0, mem_read, mem_write}, 64'd0);
        chk("rst_r_rs2",  {r, rs2}, 64'd0);
        chk("rst_rdata",  {31'd0, resp_err, resp_data}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // LW addr 0
        run_req(1'b0, 3'b010, 32'h0, 32'h0);
        chk("lw0_busy", 64'(nbusy), 64'd1);
        chk("lw0_rd",   {29'd0, tr_rd[0], tr_r[0]}, {29'd0, 3'b001, 32'h0});
        chk("lw0_rdy",  {63'd0, busy_ready}, 64'd0);
        chk("lw0_data", {32'd0, rdata}, 64'h1122_3344);

        run_req(1'b0, 3'b000, 32'h7, 32'h0);
        chk("lb7",  {32'd0, rdata}, 64'hFFFF_FF88);
        run_req(1'b0, 3'b100, 32'h7, 32'h0);
        chk("lbu7", {32'd0, rdata}, 64'h0000_0088);
        run_req(1'b0, 3'b001, 32'h2, 32'h0);
        chk("lh2",  {32'd0, rdata}, 64'h0000_1122);

`ifdef LSU_MISALIGN_TRAP_EN
        run_req(1'b0, 3'b010, 32'h2, 32'h0);
        chk("trap_busy", 64'(nbusy), 64'd0);
        chk("trap_err",  {63'd0, rerr}, 64'd1);
        chk("trap_data", {32'd0, rdata}, 64'd0);
        chk("trap_mrd",  {61'd0, mem_read}, 64'd0);
`else
        // LW addr 2 crosses into word 4
        run_req(1'b0, 3'b010, 32'h2, 32'h0);
        chk("lw2_busy", 64'(nbusy), 64'd2);
        chk("lw2_addr", {tr_r[0], tr_r[1]}, {32'h0, 32'h4});
        chk("lw2_data", {32'd0, rdata}, 64'hAABB_1122);
        chk("lw2_err",  {63'd0, rerr}, 64'd0);

        // SB addr 1
        run_req(1'b1, 3'b000, 32'h1, 32'h0000_00FF);
        chk("sb1_busy", 64'(nbusy), 64'd2);
        chk("sb1_cyc",  {59'd0, tr_rd[0], tr_wr[1]}, {59'd0, 3'b001, 2'b01});
        chk("sb1_rs2",  {32'd0, tr_rs2[1]}, 64'h1122_FF44);
        chk("sb1_rdat", {32'd0, rdata}, 64'd0);
        @(negedge clk);
        chk("sb1_mem",  {mem[0], mem[1]}, {32'h1122_FF44, 32'h8899_AABB});
        mem_reset();

        // SH addr 3, followed by a request in the resp_valid cycle
        run_req(1'b1, 3'b001, 32'h3, 32'h0000_CAFE);
        chk("sh3_busy", 64'(nbusy), 64'd4);
        chk("sh3_addr", {tr_r[0][7:0], tr_r[1][7:0], tr_r[2][7:0], tr_r[3][7:0]},
                        {32'd0, 32'h00_04_00_04});
        chk("sh3_wr",   {56'd0, tr_wr[0], tr_wr[1], tr_wr[2], tr_wr[3]}, {56'd0, 8'b00_00_01_01});
        chk("sh3_rs2",  {tr_rs2[2], tr_rs2[3]}, {32'hFE22_3344, 32'h8899_AACA});
        chk("b2b_rdy",  {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h4;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_rd",   {28'd0, req_ready, mem_read, r}, {28'd0, 1'b0, 3'b001, 32'h4});
        @(negedge clk);
        chk("b2b_resp", {31'd0, resp_valid, resp_data}, {31'd0, 1'b1, 32'h8899_AACA});
        chk("sh3_mem",  {mem[0], mem[1]}, {32'hFE22_3344, 32'h8899_AACA});
        mem_reset();

        // Reset during RD1 of the same SH
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h3; req_wdata = 32'h0000_CAFE;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_rd1", {27'd0, mem_read, mem_write, r}, {27'd0, 3'b001, 2'b00, 32'h4});
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rdy_after", {63'd0, req_ready}, 64'd1);
        saw_wr = 1'b0; saw_resp = 1'b0;
        for (int i = 0; i < 5; i++) begin
            saw_wr   = saw_wr | (mem_write == 2'b01);
            saw_resp = saw_resp | resp_valid;
            @(negedge clk);
        end
        chk("rst_no_wr_resp", {62'd0, saw_wr, saw_resp}, 64'd0);
        chk("rst_mem", {mem[0], mem[1]}, {32'h1122_3344, 32'h8899_AABB});
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
